// File: rtl/simple_proc_prog_loader.sv
// rtl/simple_proc_prog_loader.sv - program RAM loader and host/processor port arbiter
// Streams a host image into program RAM, then runs the processor until stop or cycle limit.
module simple_proc_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int RUN_LIMIT = 0,
    parameter int CNT_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    input  logic [15:0]       host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic              host_stop,
    input  logic [ADDR_W-1:0] proc_pc,
    input  logic              proc_read_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic              proc_rst_n,
    output logic              proc_start,
    output logic              busy,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic [CNT_W-1:0]  run_cycles
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_STOP} state_t;

    localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(RUN_LIMIT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    rc_q, rc_d;
    logic                image_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            wc_q    <= wc_d;
            ovf_q   <= ovf_d;
            rc_q    <= rc_d;
        end
    end

    // The word being accepted lands at address DEPTH-1.
    assign image_full = (wc_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wr_en_d = 1'b0;
        wc_d    = wc_q;
        ovf_d   = ovf_q;
        rc_d    = rc_q;
        case (state_q)
            S_IDLE: begin
                if (host_valid) begin
                    state_d = S_LOAD;
                    wc_d    = '0;
                    ovf_d   = 1'b0;
                    rc_d    = '0;
                end
            end
            S_LOAD: begin
                if (host_stop) begin
                    state_d = S_IDLE;
                end else if (host_valid) begin
                    wr_en_d = 1'b1;
                    waddr_d = wc_q[ADDR_W-1:0];
                    wdata_d = host_data;
                    wc_d    = wc_q + 1'b1;
                    if (host_last || image_full) begin
                        state_d = S_START;
                    end
                    if (!host_last && image_full) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (rc_q != '1) begin
                    rc_d = rc_q + 1'b1;
                end
                if (host_stop || ((RUN_LIMIT != 0) && (rc_q == LIMIT_M1))) begin
                    state_d = S_STOP;
                end
            end
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign host_ready = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign proc_start = (state_q == S_START);
    assign proc_rst_n = (state_q == S_START) || (state_q == S_RUN);
    // The processor owns the read port with no added latency while running.
    assign ram_addr   = (state_q == S_RUN) ? proc_pc : waddr_q;
    assign ram_rd_en  = (state_q == S_RUN) && proc_read_en;
    assign ram_wr_en  = wr_en_q;
    assign ram_wdata  = wdata_q;
    assign word_count = wc_q;
    assign overflow   = ovf_q;
    assign run_cycles = rc_q;
endmodule
